pc_fetch_ctrl: RTL and testbench

Parametrised program-counter and fetch controller for the IF stage. It supersedes the fixed 16-bit PC register. It generalises address width, instruction size, reset vector and stall-vector width. New behaviour over the previous generation: a branch redirect that arrives during a stall or a data-memory borrow is captured rather than lost, misaligned targets are detected, and instruction-fetch validity is reported explicitly. It shares the single memory port with the MEM stage, using the same read/write chip-enable convention.

---
 rtl/pc_fetch_ctrl_if.sv | 29 ++
 rtl/pc_fetch_ctrl.sv | 100 ++++++++++
 tb/tb_pc_fetch_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-controller bus: pipeline control inputs and fetch/memory-port outputs
// grouped so the IF stage and its neighbours connect through a single port.
interface pc_fetch_ctrl_if #(
    parameter int ADDR_W  = 16,
    parameter int STALL_W = 6
);
    logic [STALL_W-1:0] stall;
    logic               branch_flag_i;
    logic [ADDR_W-1:0]  branch_target_address_i;
    logic               mem_req_i;
    logic               mem_we_i;
    logic [ADDR_W-1:0]  pc;
    logic               we;
    logic               fetch_valid_o;
    logic               redirect_pending_o;
    logic               align_err_o;

    // Pipeline side: drives stall/branch/memory requests, observes fetch state
    modport master (
        output stall, branch_flag_i, branch_target_address_i, mem_req_i, mem_we_i,
        input  pc, we, fetch_valid_o, redirect_pending_o, align_err_o
    );

    // Fetch controller side
    modport slave (
        input  stall, branch_flag_i, branch_target_address_i, mem_req_i, mem_we_i,
        output pc, we, fetch_valid_o, redirect_pending_o, align_err_o
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch controller for the IF stage. Shares one memory
// port with MEM; redirects arriving while the port is borrowed or the pipe is
// stalled are held in a pending-target register until the first free cycle.
module pc_fetch_ctrl #(
    parameter int                 ADDR_W     = 16,
    parameter int                 INST_BYTES = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
    parameter int                 STALL_W    = 6
) (
    input  logic           clk,
    input  logic           rst,
    pc_fetch_ctrl_if.slave bus
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INST_BYTES - 1);
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(INST_BYTES);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_REDIR = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic              align_err_q, align_err_d;

    logic              blocked;
    logic [ADDR_W-1:0] tgt_aligned;
    logic              tgt_misaligned;
    logic              unused_stall;

    // Only stall[0] freezes this stage; the rest of the vector belongs to later stages.
    assign unused_stall   = ^bus.stall;
    assign blocked        = bus.mem_req_i | bus.stall[0];
    // With INST_BYTES=1 the mask is zero, so no target is ever flagged.
    assign tgt_aligned    = bus.branch_target_address_i & ~ALIGN_MASK;
    assign tgt_misaligned = |(bus.branch_target_address_i & ALIGN_MASK);

    // State, PC, pending target and error pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_PC;
            pend_q      <= '0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            align_err_q <= align_err_d;
        end
    end

    // Next state: redirect capture while blocked, branch > pending > sequential when free
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        align_err_d = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN, ST_REDIR: begin
                if (blocked) begin
                    if (bus.branch_flag_i) begin
                        pend_d      = tgt_aligned;
                        state_d     = ST_REDIR;
                        align_err_d = tgt_misaligned;
                    end
                end else if (bus.branch_flag_i) begin
                    pc_d        = tgt_aligned;
                    state_d     = ST_RUN;
                    align_err_d = tgt_misaligned;
                end else if (state_q == ST_REDIR) begin
                    pc_d    = pend_q;
                    state_d = ST_RUN;
                end else begin
                    pc_d = pc_q + PC_STEP;
                end
            end
            default: begin
                // Unused encoding: resume normal fetch without disturbing the PC
                state_d = ST_RUN;
            end
        endcase
    end

    // Outputs: chip enable and fetch validity follow the current-cycle port usage
    always_comb begin
        bus.pc                 = pc_q;
        bus.we                 = bus.mem_req_i & bus.mem_we_i;
        bus.fetch_valid_o      = (state_q != ST_BOOT) & ~bus.mem_req_i & ~bus.stall[0];
        bus.redirect_pending_o = (state_q == ST_REDIR);
        bus.align_err_o        = align_err_q;
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: per-cycle expectations from a
// reference model go through a scoreboard queue; directed scenarios add
// fixed-value checks.
module tb_pc_fetch_ctrl;

    localparam int ADDR_W     = 16;
    localparam int INST_BYTES = 2;
    localparam int STALL_W    = 6;

    logic clk;
    logic rst;

    pc_fetch_ctrl_if #(.ADDR_W(ADDR_W), .STALL_W(STALL_W)) bif ();

    pc_fetch_ctrl #(
        .ADDR_W    (ADDR_W),
        .INST_BYTES(INST_BYTES),
        .RESET_PC  (16'h0000),
        .STALL_W   (STALL_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic        we;
        logic        fv;
        logic        pend;
        logic        aerr;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] m_pc;
    logic        m_boot;
    logic        m_pend;
    logic [15:0] m_ptgt;
    logic        m_aerr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc   = 16'h0000;
        m_boot = 1'b1;
        m_pend = 1'b0;
        m_ptgt = 16'h0000;
        m_aerr = 1'b0;
        sb.delete();
    endtask

    task automatic idle_inputs();
        bif.stall                   = '0;
        bif.branch_flag_i           = 1'b0;
        bif.branch_target_address_i = '0;
        bif.mem_req_i               = 1'b0;
        bif.mem_we_i                = 1'b0;
    endtask

    // One clock cycle: drive inputs, queue expected outputs, compare at negedge,
    // advance the model, return at posedge+1.
    task automatic cycle(input logic br, input logic [15:0] tgt,
                         input logic req, input logic wr, input logic st);
        exp_t e;
        exp_t g;
        logic [15:0] rem;
        bif.branch_flag_i           = br;
        bif.branch_target_address_i = tgt;
        bif.mem_req_i               = req;
        bif.mem_we_i                = wr;
        bif.stall                   = {5'($urandom), st};
        e.pc   = m_pc;
        e.we   = req && wr;
        e.fv   = !m_boot && !req && !st;
        e.pend = m_pend;
        e.aerr = m_aerr;
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            g = sb.pop_front();
            chk("pc",   bif.pc,                 g.pc);
            chk("we",   bif.we,                 g.we);
            chk("fv",   bif.fetch_valid_o,      g.fv);
            chk("pend", bif.redirect_pending_o, g.pend);
            chk("aerr", bif.align_err_o,        g.aerr);
        end
        rem = tgt % INST_BYTES;
        if (m_boot) begin
            m_boot = 1'b0;
            m_aerr = 1'b0;
        end else begin
            m_aerr = br && (rem != 0);
            if (req || st) begin
                if (br) begin
                    m_pend = 1'b1;
                    m_ptgt = tgt - rem;
                end
            end else if (br) begin
                m_pc   = tgt - rem;
                m_pend = 1'b0;
            end else if (m_pend) begin
                m_pc   = m_ptgt;
                m_pend = 1'b0;
            end else begin
                m_pc = 16'((32'(m_pc) + INST_BYTES) % 65536);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic free_cycle();
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic branch(input logic [15:0] tgt);
        cycle(1'b1, tgt, 1'b0, 1'b0, 1'b0);
    endtask

    // Reset asserted mid-cycle; checked before any clock edge, released one cycle later
    task automatic do_reset();
        idle_inputs();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_pc",   bif.pc,                 32'h0000);
        chk("rst_fv",   bif.fetch_valid_o,      32'd0);
        chk("rst_pend", bif.redirect_pending_o, 32'd0);
        chk("rst_aerr", bif.align_err_o,        32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        repeat (4) free_cycle();

        // Reset then free-run: BOOT cycle then 2, 4, 6
        do_reset();
        free_cycle();
        chk("boot_hold", bif.pc, 32'h0000);
        free_cycle();
        chk("run_pc2", bif.pc, 32'h0002);
        free_cycle();
        chk("run_pc4", bif.pc, 32'h0004);
        free_cycle();
        chk("run_pc6", bif.pc, 32'h0006);

        // Unblocked branch
        branch(16'h0010);
        branch(16'h0100);
        chk("br_pc", bif.pc, 32'h0100);
        free_cycle();
        chk("br_next", bif.pc, 32'h0102);
        chk("br_nopend", bif.redirect_pending_o, 32'd0);

        // Branch during stall, released after three stalled cycles
        branch(16'h0020);
        cycle(1'b1, 16'h0200, 1'b0, 1'b0, 1'b1);
        chk("st_hold", bif.pc, 32'h0020);
        chk("st_pend", bif.redirect_pending_o, 32'd1);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("st_hold3", bif.pc, 32'h0020);
        free_cycle();
        chk("st_apply", bif.pc, 32'h0200);
        chk("st_clear", bif.redirect_pending_o, 32'd0);

        // Memory write borrow with overwriting branches
        cycle(1'b1, 16'h0300, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 16'h0400, 1'b1, 1'b1, 1'b0);
        chk("mem_hold", bif.pc, 32'h0200);
        free_cycle();
        chk("mem_newest", bif.pc, 32'h0400);

        // Branch beats pending redirect in the same free cycle
        cycle(1'b1, 16'h0500, 1'b0, 1'b0, 1'b1);
        branch(16'h0600);
        chk("bvp_pc", bif.pc, 32'h0600);
        chk("bvp_pend", bif.redirect_pending_o, 32'd0);
        free_cycle();
        chk("bvp_next", bif.pc, 32'h0602);

        // Misaligned targets: applied, then captured
        branch(16'h0101);
        chk("mis_pc", bif.pc, 32'h0100);
        chk("mis_err", bif.align_err_o, 32'd1);
        free_cycle();
        chk("mis_once", bif.align_err_o, 32'd0);
        cycle(1'b1, 16'h0203, 1'b1, 1'b0, 1'b0);
        chk("mis_cap_err", bif.align_err_o, 32'd1);
        free_cycle();
        chk("mis_cap_pc", bif.pc, 32'h0202);

        // Wrap at top of address space
        branch(16'hFFFE);
        free_cycle();
        chk("wrap", bif.pc, 32'h0000);

        // Reset while a redirect is pending
        cycle(1'b1, 16'h0700, 1'b0, 1'b0, 1'b1);
        chk("pre_rst_pend", bif.redirect_pending_o, 32'd1);
        do_reset();
        free_cycle();
        free_cycle();
        chk("post_rst_pc", bif.pc, 32'h0002);

        // Mixed random traffic against the model
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 3) == 0), 16'($urandom),
                  ($urandom_range(0, 4) == 0), 1'($urandom),
                  ($urandom_range(0, 4) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
